// File: rtl/ram_lsu.sv
// rtl/ram_lsu.sv - load/store front-end for the single-port 1k x 32 ram
// Sub-word stores are read-modify-write; loads are extended to 32 bits.
module ram_lsu #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic          rsp_error,
  output logic [31:0]   rsp_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RDATA, MERGE, WR, ERR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, state_n;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;
  logic        unused_addr_hi;

  // Address bits above the word index are dropped so the address wraps.
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign accept     = req_valid && (state == IDLE);
  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  always_comb begin
    ld_byte = ram_rdata[{lane_q, 3'b000} +: 8];
    ld_half = ram_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = ram_rdata;
    endcase
  end

  always_comb begin
    merged = ram_rdata;
    if (size_q == SZ_BYTE)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        lane_q   <= req_addr[1:0];
        size_q   <= req_size;
        write_q  <= req_write;
        uns_q    <= req_unsigned;
        wdata_q  <= req_wdata;
        ram_addr <= req_addr[AW+1:2];
        if (req_write && req_size == SZ_WORD && !misaligned)
          ram_wdata <= req_wdata;
      end
      // ram_rdata of the RD access is valid during MERGE; capture the merged word for WR.
      if (state == MERGE)
        ram_wdata <= merged;
    end
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    ram_we    = 1'b0;
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    rsp_rdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)
            state_n = ERR;
          else if (req_write && req_size == SZ_WORD)
            state_n = WR;
          else
            state_n = RD;
        end
      end
      RD:    state_n = write_q ? MERGE : RDATA;
      RDATA: begin
        rsp_valid = 1'b1;
        rsp_rdata = ld_ext;
        state_n   = IDLE;
      end
      MERGE: state_n = WR;
      WR: begin
        ram_we    = 1'b1;
        rsp_valid = 1'b1;
        state_n   = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_error = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_lsu.sv
// tb/tb_ram_lsu.sv - scoreboard bench for ram_lsu with a behavioural 1k x 32 ram
// Issued requests push expected responses and ram writes; a negedge monitor pops and compares.
module tb_ram_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;

  ram_lsu #(.DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void bad(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    if (rsp_valid) begin
      if (rq.size() == 0) bad("unexpected_rsp");
      else begin
        r = rq.pop_front();
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, r.err});
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
      end
    end else if (rsp_error || rsp_rdata != 0) begin
      bad("rsp_fields_without_valid");
    end
    if (ram_we) begin
      if (wq.size() == 0) bad("unexpected_ram_we");
      else begin
        w = wq.pop_front();
        chk("wr_addr", {22'd0, ram_addr}, {22'd0, w.addr});
        chk("wr_data", ram_wdata, w.data);
        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  // Waits for req_ready, presents the request, records expectations, returns just after the accept edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd, input logic [31:0] exp_word,
                       input bit track, output int acc, output int waits);
    int   lat;
    rsp_t r;
    wr_t  x;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) bad("req_ready_timeout");
    req_valid    = 1'b1;
    req_write    = w;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    req_wdata    = wd;
    acc = cyc;
    if (exp_err)          lat = 1;
    else if (!w)          lat = 2;
    else if (sz == 2'b10) lat = 1;
    else                  lat = 3;
    if (track) begin
      r.err = exp_err; r.rdata = exp_rd; r.cyc = acc + lat;
      rq.push_back(r);
      if (w && !exp_err) begin
        x.addr = a[11:2]; x.data = exp_word; x.cyc = acc + lat;
        wq.push_back(x);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                       input logic [31:0] exp_word);
    int acc, waits;
    issue(1'b1, a, sz, 1'b0, wd, 1'b0, 32'd0, exp_word, 1'b1, acc, waits);
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                      input logic [31:0] exp_rd);
    int acc, waits;
    issue(1'b0, a, sz, u, 32'd0, 1'b0, exp_rd, 32'd0, 1'b1, acc, waits);
    req_valid = 1'b0;
  endtask

  task automatic bad_req(input logic w, input logic [31:0] a, input logic [1:0] sz);
    int acc, waits;
    issue(w, a, sz, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0, 1'b1, acc, waits);
    req_valid = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, w0, w1, w2;
    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    store(32'h10, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load (32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);

    store(32'h20, 2'b10, 32'h1122_3344, 32'h1122_3344);
    store(32'h22, 2'b00, 32'hFFFF_FFAA, 32'h11AA_3344);
    load (32'h20, 2'b10, 1'b0, 32'h11AA_3344);

    store(32'h30, 2'b10, 32'h80FF_7F01, 32'h80FF_7F01);
    load (32'h31, 2'b00, 1'b0, 32'h0000_007F);
    load (32'h32, 2'b00, 1'b0, 32'hFFFF_FFFF);
    load (32'h33, 2'b00, 1'b1, 32'h0000_0080);
    load (32'h32, 2'b01, 1'b1, 32'h0000_80FF);
    load (32'h32, 2'b01, 1'b0, 32'hFFFF_80FF);
    store(32'h32, 2'b01, 32'h1234_BEEF, 32'hBEEF_7F01);
    load (32'h30, 2'b10, 1'b0, 32'hBEEF_7F01);

    store(32'h04, 2'b10, 32'hCAFE_F00D, 32'hCAFE_F00D);
    bad_req(1'b0, 32'h02, 2'b10);
    bad_req(1'b1, 32'h05, 2'b01);
    bad_req(1'b1, 32'h10, 2'b11);

    // Three loads with req_valid held high between them.
    issue(1'b0, 32'h10,   2'b10, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, a0, w0);
    issue(1'b0, 32'h1004, 2'b10, 1'b0, 32'd0, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b1, a1, w1);
    issue(1'b0, 32'h20,   2'b10, 1'b0, 32'd0, 1'b0, 32'h11AA_3344, 32'd0, 1'b1, a2, w2);
    req_valid = 1'b0;
    chk("b2b_busy_cycles_1", 32'(w1), 32'd2);
    chk("b2b_busy_cycles_2", 32'(w2), 32'd2);
    chk("b2b_spacing", 32'(a2 - a0), 32'd6);

    // Reset during MERGE of a byte RMW: no write, no response, word preserved.
    store(32'h40, 2'b10, 32'h1122_3344, 32'h1122_3344);
    issue(1'b1, 32'h41, 2'b00, 1'b0, 32'h55, 1'b0, 32'd0, 32'd0, 1'b0, a0, w0);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    load(32'h40, 2'b10, 1'b0, 32'h1122_3344);
    load(32'h41, 2'b00, 1'b1, 32'h0000_0033);

    repeat (6) @(negedge clk);
    chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
    chk("wr_queue_drained", 32'(wq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
